multicycle_control: RTL



---
 rtl/cpu_ctrl_pkg.sv | 27 ++
 rtl/mc_wait_timer.sv | 27 ++
 rtl/multicycle_control.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control FSM:
// state encoding, supported opcodes and ALUOp codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts non-acknowledged data-memory cycles while the FSM sits in MEM and
// flags the cycle in which one more miss would exceed the wait budget.
module mc_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic at_limit
);

    logic [WAIT_W-1:0] count;

    // Cleared whenever MEM is not occupied or the access completes.
    always_ff @(posedge clk) begin
        if (rst || !active || ack) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == WAIT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB, HALT on bad opcode
// or memory timeout). Define MC_RETIRE_CNT_EN to add the retired-instruction counter.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W    = 6,
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4,
    parameter int RET_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic             dm_ack,
    output logic             pc_write,
    output logic             im_en,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             dm_req,
    output logic             dm_we,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             halted,
    output logic [2:0]       state_o
`ifdef MC_RETIRE_CNT_EN
    ,
    output logic [RET_W-1:0] retired
`endif
);

    state_t           state;
    state_t           next_state;
    logic [OPC_W-1:0] op_q;
    logic             at_limit;

    mc_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .active   (state == MEM),
        .ack      (dm_ack),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The opcode is only trusted from DECODE on, so it is frozen here for EXEC/MEM/WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
        end else if (state == DECODE) begin
            op_q <= opcode;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   next_state = run ? FETCH : IDLE;
            FETCH:  next_state = DECODE;
            DECODE: next_state = is_supported(opcode) ? EXEC : HALT;
            EXEC:   next_state = (op_q == OP_LW || op_q == OP_SW) ? MEM : WB;
            MEM: begin
                if (dm_ack) begin
                    if (op_q == OP_LW) begin
                        next_state = WB;
                    end else begin
                        next_state = run ? FETCH : IDLE;
                    end
                end else if (at_limit) begin
                    next_state = HALT;
                end
            end
            WB:     next_state = run ? FETCH : IDLE;
            HALT:   next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Outputs follow the state and latched opcode; the single exception is a
    // store's pc_write, which must coincide with the acknowledging cycle.
    always_comb begin
        pc_write   = 1'b0;
        im_en      = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALUOP_ADD;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH:  im_en    = 1'b1;
            DECODE: ir_write = 1'b1;
            EXEC: begin
                if (op_q == OP_RTYPE) begin
                    alu_op  = ALUOP_FUNCT;
                    alu_src = 1'b0;
                end else begin
                    alu_op  = ALUOP_ADD;
                    alu_src = 1'b1;
                end
            end
            MEM: begin
                dm_req   = 1'b1;
                dm_we    = (op_q == OP_SW);
                pc_write = (op_q == OP_SW) && dm_ack;
            end
            WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                reg_dst    = (op_q == OP_RTYPE);
                mem_to_reg = (op_q == OP_LW);
            end
            HALT:   halted = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

`ifdef MC_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (pc_write) begin
            retired <= retired + 1'b1;
        end
    end
`endif

endmodule
